// File: rtl/uart_tx_buffered_port_if.sv
// Core-side load/store port of the UART transmit peripheral, driven by the memory map decoder.
interface uart_tx_buffered_port_if #(
  parameter int DATA_LENGTH = 32
);
  logic [3:0]             address;
  logic                   select;
  logic                   write;
  logic [DATA_LENGTH-1:0] data_in;
  logic [DATA_LENGTH-1:0] data_out;

  modport master (output address, select, write, data_in, input data_out);
  modport slave  (input address, select, write, data_in, output data_out);
endinterface

// File: rtl/uart_tx_buffered_port.sv
// Memory-mapped 8N1 UART transmitter: stores queue bytes in an 8-deep FIFO and
// the baud FSM drains it back-to-back, so firmware only polls STATUS.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (line low) for one bit period
// DATA  | shifter[0] on the line, LSB first, 8 bit periods
// STOP  | stop bit (line high); pops the next byte at its end if one is waiting
module uart_tx_buffered_port #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_AW     = 3,
  parameter int DATA_LENGTH = 32
) (
  input  logic                   clk_sys,
  input  logic                   rst_b,
  uart_tx_buffered_port_if.slave bus,
  output logic                   tx,
  output logic                   tx_busy,
  output logic [FIFO_AW:0]       fifo_count
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(DIV);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   OCC_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   OCC_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [7:0]           shifter, shifter_n;
  logic [CW-1:0]        baud_cnt, baud_n;
  logic [2:0]           bit_idx, bit_n;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 overflow;
  logic                 full, empty, pop, bit_end;
  logic                 push, push_ok, flush, clr_ovf, ovf_set, ctrl_wr;
  logic [DATA_LENGTH-1:0] status;
  logic                 unused_data_bits;

  assign unused_data_bits = ^bus.data_in[DATA_LENGTH-1:8];

  assign full    = (count == OCC_FULL);
  assign empty   = (count == '0);
  assign push    = bus.select && bus.write && (bus.address == 4'h0);
  assign ctrl_wr = bus.select && bus.write && (bus.address == 4'h8);
  assign flush   = ctrl_wr && bus.data_in[0];
  assign clr_ovf = ctrl_wr && bus.data_in[1];
  // a pop in the same cycle frees the slot, so a push at full is still taken
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop && !flush;

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   count <= count + OCC_ONE;
          2'b01:   count <= count - OCC_ONE;
          default: count <= count;
        endcase
      end
      if (clr_ovf) overflow <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok && !flush) mem[wr_ptr] <= bus.data_in[7:0];
  end

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      state    <= IDLE;
      shifter  <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_n;
      shifter  <= shifter_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
    end
  end

  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shifter_n = mem[rd_ptr];
          baud_n    = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n    = '0;
          shifter_n = {1'b0, shifter[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (!empty) begin
            pop       = 1'b1;
            shifter_n = mem[rd_ptr];
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (state == START)     tx = 1'b0;
    else if (state == DATA) tx = shifter[0];
  end

  assign tx_busy    = (state != IDLE);
  assign fifo_count = count;

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = tx_busy;
    status[3]   = overflow;
    status[7:4] = 4'(count);
  end

  assign bus.data_out = (bus.select && !bus.write && bus.address == 4'h4) ? status : '0;
endmodule
